// File: rtl/fp_div_pipe.sv
// Fully pipelined IEEE 754 binary floating-point divider (result = a / b).
// One operation accepted per cycle, fixed latency of MANT_W+5 cycles, no backpressure.
// Pipeline: unpack register, MANT_W+3 restoring-division stages, then a registered
// normalise / round / pack stage. Special operands bypass the divider and travel with the op.
module fp_div_pipe #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23,
    parameter int TAG_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [EXP_W+MANT_W:0] a,
    input  logic [EXP_W+MANT_W:0] b,
    input  logic [1:0]            rm,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    output logic [EXP_W+MANT_W:0] result,
    output logic [4:0]            flags,
    output logic [TAG_W-1:0]      out_tag
);

    localparam int W    = 1 + EXP_W + MANT_W;
    localparam int Q_W  = MANT_W + 3;
    localparam int EW   = EXP_W + 2;
    localparam int RW   = MANT_W + 2;
    localparam int LZ_W = $clog2(MANT_W + 2);

    localparam logic [1:0] RM_RNE = 2'b00;
    localparam logic [1:0] RM_RTZ = 2'b01;
    localparam logic [1:0] RM_RDN = 2'b10;
    localparam logic [1:0] RM_RUP = 2'b11;

    typedef logic signed [EW-1:0] sexp_t;

    localparam sexp_t       BIAS   = sexp_t'((1 << (EXP_W - 1)) - 1);
    localparam sexp_t       MAX_E  = sexp_t'((1 << EXP_W) - 1);
    localparam sexp_t       ONE_E  = sexp_t'(1);
    localparam logic [EW-1:0] SH_LIM = EW'(RW);

    // Everything an operation carries from one pipeline stage to the next.
    typedef struct packed {
        logic                  valid;
        logic                  sign;
        sexp_t                 expo;
        logic [MANT_W:0]       divisor;
        logic [RW-1:0]         rem;
        logic [Q_W-1:0]        quo;
        logic                  special;
        logic [W-1:0]          specRes;
        logic [4:0]            specFlags;
        logic [1:0]            rm;
        logic [TAG_W-1:0]      tag;
    } stage_t;

    // Leading-zero count over the (hidden bit + fraction) field.
    function automatic logic [LZ_W-1:0] leadZeros(input logic [MANT_W:0] m);
        logic [LZ_W-1:0] cnt;
        logic            found;
        cnt   = '0;
        found = 1'b0;
        for (int i = MANT_W; i >= 0; i--) begin
            if (!found) begin
                if (m[i]) found = 1'b1;
                else      cnt   = cnt + LZ_W'(1);
            end
        end
        return cnt;
    endfunction

    // ------------------------------------------------------------------
    // Unpack and classify
    // ------------------------------------------------------------------
    logic              w_signA, w_signB;
    logic [EXP_W-1:0]  w_expA, w_expB;
    logic [MANT_W-1:0] w_fracA, w_fracB;
    logic              w_expAOnes, w_expBOnes, w_expAZero, w_expBZero;
    logic              w_fracAZero, w_fracBZero;
    logic              w_nanA, w_nanB, w_snanA, w_snanB;
    logic              w_infA, w_infB, w_zeroA, w_zeroB, w_subA, w_subB;
    logic [MANT_W:0]   w_rawA, w_rawB, w_mantA, w_mantB;
    logic [LZ_W-1:0]   w_lzA, w_lzB;
    sexp_t             w_effA, w_effB, w_expDiff;
    logic              w_sign;
    logic [W-1:0]      w_qnan;

    assign w_signA     = a[W-1];
    assign w_signB     = b[W-1];
    assign w_expA      = a[W-2:MANT_W];
    assign w_expB      = b[W-2:MANT_W];
    assign w_fracA     = a[MANT_W-1:0];
    assign w_fracB     = b[MANT_W-1:0];
    assign w_expAOnes  = &w_expA;
    assign w_expBOnes  = &w_expB;
    assign w_expAZero  = ~|w_expA;
    assign w_expBZero  = ~|w_expB;
    assign w_fracAZero = ~|w_fracA;
    assign w_fracBZero = ~|w_fracB;
    assign w_nanA      = w_expAOnes & ~w_fracAZero;
    assign w_nanB      = w_expBOnes & ~w_fracBZero;
    assign w_snanA     = w_nanA & ~w_fracA[MANT_W-1];
    assign w_snanB     = w_nanB & ~w_fracB[MANT_W-1];
    assign w_infA      = w_expAOnes & w_fracAZero;
    assign w_infB      = w_expBOnes & w_fracBZero;
    assign w_zeroA     = w_expAZero & w_fracAZero;
    assign w_zeroB     = w_expBZero & w_fracBZero;
    assign w_subA      = w_expAZero & ~w_fracAZero;
    assign w_subB      = w_expBZero & ~w_fracBZero;

    // Subnormals are shifted so the hidden bit is set; their exponent becomes 1 - lz.
    assign w_rawA    = {~w_expAZero, w_fracA};
    assign w_rawB    = {~w_expBZero, w_fracB};
    assign w_lzA     = leadZeros(w_rawA);
    assign w_lzB     = leadZeros(w_rawB);
    assign w_mantA   = w_subA ? (w_rawA << w_lzA) : w_rawA;
    assign w_mantB   = w_subB ? (w_rawB << w_lzB) : w_rawB;
    assign w_effA    = w_subA ? (ONE_E - sexp_t'(w_lzA)) : sexp_t'({2'b00, w_expA});
    assign w_effB    = w_subB ? (ONE_E - sexp_t'(w_lzB)) : sexp_t'({2'b00, w_expB});
    assign w_expDiff = w_effA - w_effB + BIAS;
    assign w_sign    = w_signA ^ w_signB;
    assign w_qnan    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};

    stage_t w_s1;
    stage_t r_s1;

    // Build the first pipeline word and resolve the special-operand cases by priority.
    always_comb begin
        w_s1           = '0;
        w_s1.valid     = in_valid;
        w_s1.sign      = w_sign;
        w_s1.expo      = w_expDiff;
        w_s1.divisor   = w_mantB;
        w_s1.rem       = {1'b0, w_mantA};
        w_s1.rm        = rm;
        w_s1.tag       = in_tag;
        if (w_nanA | w_nanB | (w_zeroA & w_zeroB) | (w_infA & w_infB)) begin
            w_s1.special   = 1'b1;
            w_s1.specRes   = w_qnan;
            w_s1.specFlags = {((w_zeroA & w_zeroB) | (w_infA & w_infB) | w_snanA | w_snanB), 4'b0000};
        end else if (w_infA | w_zeroB) begin
            w_s1.special   = 1'b1;
            w_s1.specRes   = {w_sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
            w_s1.specFlags = {1'b0, (w_zeroB & ~w_infA), 3'b000};
        end else if (w_zeroA | w_infB) begin
            w_s1.special   = 1'b1;
            w_s1.specRes   = {w_sign, {(W-1){1'b0}}};
            w_s1.specFlags = 5'b00000;
        end
    end

    // ------------------------------------------------------------------
    // Restoring division, one quotient bit per stage
    // ------------------------------------------------------------------
    stage_t        r_div     [Q_W];
    stage_t        w_divIn   [Q_W];
    stage_t        w_divNext [Q_W];
    logic          w_ge      [Q_W];
    logic [RW-1:0] w_remOut  [Q_W];

    // Each stage compares the partial remainder with the divisor, subtracts when it fits,
    // shifts the remainder left for the next stage and appends the quotient bit.
    always_comb begin
        for (int k = 0; k < Q_W; k++) begin
            if (k == 0) w_divIn[k] = r_s1;
            else        w_divIn[k] = r_div[k-1];
            w_ge[k]          = (w_divIn[k].rem >= {1'b0, w_divIn[k].divisor});
            w_remOut[k]      = w_ge[k] ? (w_divIn[k].rem - {1'b0, w_divIn[k].divisor})
                                       : w_divIn[k].rem;
            w_divNext[k]     = w_divIn[k];
            w_divNext[k].rem = {w_remOut[k][RW-2:0], 1'b0};
            w_divNext[k].quo = {w_divIn[k].quo[Q_W-2:0], w_ge[k]};
        end
    end

    // Unpack register and divider stage registers; reset drops every in-flight op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= '0;
            for (int k = 0; k < Q_W; k++) r_div[k] <= '0;
        end else begin
            r_s1 <= w_s1;
            for (int k = 0; k < Q_W; k++) r_div[k] <= w_divNext[k];
        end
    end

    // ------------------------------------------------------------------
    // Normalise, denormalise, round, pack
    // ------------------------------------------------------------------
    stage_t          w_last;
    logic [MANT_W:0] w_mant, w_mantF;
    logic            w_rnd, w_stk, w_rndF, w_stkF;
    sexp_t           w_e, w_eFin;
    logic            w_tiny, w_nx, w_inc, w_ovf, w_toInf;
    logic [EW-1:0]   w_sh;
    logic [RW-1:0]   w_ext, w_extSh, w_lostMask;
    logic [MANT_W+1:0] w_mantR;
    logic [W-1:0]    w_res;
    logic [4:0]      w_flg;

    assign w_last = r_div[Q_W-1];

    // Bring the quotient's leading one to the hidden-bit position and derive round/sticky.
    always_comb begin
        if (w_last.quo[Q_W-1]) begin
            w_mant = w_last.quo[Q_W-1:2];
            w_rnd  = w_last.quo[1];
            w_stk  = w_last.quo[0] | (|w_last.rem);
            w_e    = w_last.expo;
        end else begin
            w_mant = w_last.quo[Q_W-2:1];
            w_rnd  = w_last.quo[0];
            w_stk  = |w_last.rem;
            w_e    = w_last.expo - ONE_E;
        end
    end

    // Results below the normal range are shifted right into subnormal position;
    // everything shifted past the round bit collapses into sticky.
    always_comb begin
        w_tiny     = w_e[EW-1] | (w_e == '0);
        w_sh       = ONE_E - w_e;
        w_ext      = {w_mant, w_rnd};
        w_extSh    = '0;
        w_lostMask = '0;
        w_mantF    = w_mant;
        w_rndF     = w_rnd;
        w_stkF     = w_stk;
        if (w_tiny) begin
            if (w_sh >= SH_LIM) begin
                w_mantF = '0;
                w_rndF  = 1'b0;
                w_stkF  = w_stk | (|w_ext);
            end else begin
                w_extSh    = w_ext >> w_sh;
                w_lostMask = ~({RW{1'b1}} << w_sh);
                w_mantF    = w_extSh[RW-1:1];
                w_rndF     = w_extSh[0];
                w_stkF     = w_stk | (|(w_ext & w_lostMask));
            end
        end
    end

    // Apply the op's own rounding mode and fix up the exponent after a mantissa carry.
    always_comb begin
        w_nx = w_rndF | w_stkF;
        case (w_last.rm)
            RM_RNE:  w_inc = w_rndF & (w_stkF | w_mantF[0]);
            RM_RTZ:  w_inc = 1'b0;
            RM_RDN:  w_inc = w_last.sign & w_nx;
            RM_RUP:  w_inc = ~w_last.sign & w_nx;
            default: w_inc = 1'b0;
        endcase
        w_mantR = {1'b0, w_mantF} + {{(MANT_W+1){1'b0}}, w_inc};
        if (w_tiny) w_eFin = w_mantR[MANT_W] ? ONE_E : '0;
        else        w_eFin = w_e + {{(EW-1){1'b0}}, w_mantR[MANT_W+1]};
        w_ovf   = ~w_tiny & (w_eFin >= MAX_E);
        w_toInf = (w_last.rm == RM_RNE) |
                  ((w_last.rm == RM_RDN) & w_last.sign) |
                  ((w_last.rm == RM_RUP) & ~w_last.sign);
    end

    // Select between bypassed special result, overflow result and the rounded quotient.
    always_comb begin
        if (w_last.special) begin
            w_res = w_last.specRes;
            w_flg = w_last.specFlags;
        end else if (w_ovf) begin
            if (w_toInf) w_res = {w_last.sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
            else         w_res = {w_last.sign, {(EXP_W-1){1'b1}}, 1'b0, {MANT_W{1'b1}}};
            w_flg = 5'b00101;
        end else begin
            w_res = {w_last.sign, w_eFin[EXP_W-1:0],
                     (w_mantR[MANT_W+1] ? {MANT_W{1'b0}} : w_mantR[MANT_W-1:0])};
            w_flg = {3'b000, (w_tiny & w_nx), w_nx};
        end
    end

    logic             r_outValid;
    logic [W-1:0]     r_result;
    logic [4:0]       r_flags;
    logic [TAG_W-1:0] r_outTag;

    // Output register: data only updates with a valid op and holds through bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outValid <= 1'b0;
            r_result   <= '0;
            r_flags    <= '0;
            r_outTag   <= '0;
        end else begin
            r_outValid <= w_last.valid;
            if (w_last.valid) begin
                r_result <= w_res;
                r_flags  <= w_flg;
                r_outTag <= w_last.tag;
            end
        end
    end

    assign out_valid = r_outValid;
    assign result    = r_result;
    assign flags     = r_flags;
    assign out_tag   = r_outTag;

endmodule

// File: tb/tb_fp_div_pipe.sv
// Directed self-checking bench for fp_div_pipe (single-precision defaults).
module tb_fp_div_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] a, b;
    logic [1:0]  rm;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic [31:0] result;
    logic [4:0]  flags;
    logic [3:0]  out_tag;

    int checks = 0;
    int errors = 0;

    logic [36:0] expQ[$];
    logic [3:0]  tagQ[$];

    fp_div_pipe #(.EXP_W(8), .MANT_W(23), .TAG_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .rm        (rm),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .result    (result),
        .flags     (flags),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    // Watchdog so the bench can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] va, input logic [31:0] vb,
                                 input logic [1:0] vrm, input logic [3:0] vtag);
        in_valid = 1'b1;
        a        = va;
        b        = vb;
        rm       = vrm;
        in_tag   = vtag;
    endtask

    task automatic idleInputs();
        in_valid = 1'b0;
        a        = 32'h0;
        b        = 32'h0;
        rm       = 2'b00;
        in_tag   = 4'h0;
    endtask

    // Issue one op, wait (bounded) for it, check latency, result, flags, tag and the drop afterwards.
    task automatic runOp(input string name, input logic [31:0] va, input logic [31:0] vb,
                         input logic [1:0] vrm, input logic [3:0] vtag,
                         input logic [31:0] expRes, input logic [4:0] expFlags);
        int cyc;
        @(negedge clk);
        applyStimulus(va, vb, vrm, vtag);
        @(negedge clk);
        idleInputs();
        cyc = 1;
        while (out_valid !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput({name, "/latency"}, 64'(cyc), 64'd28);
        checkOutput({name, "/valid"},   64'(out_valid), 64'd1);
        checkOutput({name, "/result"},  64'(result), 64'(expRes));
        checkOutput({name, "/flags"},   64'(flags), 64'(expFlags));
        checkOutput({name, "/tag"},     64'(out_tag), 64'(vtag));
        @(negedge clk);
        checkOutput({name, "/drop"},    64'(out_valid), 64'd0);
    endtask

    // Integer long-division reference for normal operands whose quotient stays normal.
    function automatic logic [36:0] refDiv(input logic [31:0] x, input logic [31:0] y, input logic [1:0] mode);
        logic [63:0] num, den, q, r;
        int          e;
        logic [23:0] mant;
        logic        rnd, stk, sgn, inc, nx;
        logic [24:0] mr;
        sgn = x[31] ^ y[31];
        num = {40'd0, 1'b1, x[22:0]} << 26;
        den = {40'd0, 1'b1, y[22:0]};
        q   = num / den;
        r   = num % den;
        e   = int'(x[30:23]) - int'(y[30:23]) + 127;
        if (q[26]) begin
            mant = q[26:3];
            rnd  = q[2];
            stk  = (q[1:0] != 2'b00) || (r != 64'd0);
        end else begin
            mant = q[25:2];
            rnd  = q[1];
            stk  = q[0] || (r != 64'd0);
            e    = e - 1;
        end
        nx = rnd | stk;
        case (mode)
            2'b00:   inc = rnd & (stk | mant[0]);
            2'b01:   inc = 1'b0;
            2'b10:   inc = sgn & nx;
            default: inc = ~sgn & nx;
        endcase
        mr = {1'b0, mant} + {24'd0, inc};
        if (mr[24]) e = e + 1;
        return {4'b0000, nx, sgn, e[7:0], mr[22:0]};
    endfunction

    initial begin
        logic [31:0] ra, rb;
        logic [1:0]  rrm;
        logic [36:0] popped;
        logic [3:0]  poppedTag;
        logic        expV;
        int          strayValid;

        rst_n = 1'b0;
        idleInputs();
        repeat (3) @(negedge clk);
        checkOutput("reset/valid",  64'(out_valid), 64'd0);
        checkOutput("reset/result", 64'(result),    64'd0);
        checkOutput("reset/flags",  64'(flags),     64'd0);
        checkOutput("reset/tag",    64'(out_tag),   64'd0);
        rst_n = 1'b1;

        // Basic and rounding-mode vectors
        runOp("six_div_two", 32'h40C00000, 32'h40000000, 2'b00, 4'd5, 32'h40400000, 5'h00);
        runOp("third_rne",   32'h3F800000, 32'h40400000, 2'b00, 4'd1, 32'h3EAAAAAB, 5'h01);
        runOp("third_rtz",   32'h3F800000, 32'h40400000, 2'b01, 4'd2, 32'h3EAAAAAA, 5'h01);
        runOp("third_rdn",   32'h3F800000, 32'h40400000, 2'b10, 4'd3, 32'h3EAAAAAA, 5'h01);
        runOp("third_rup",   32'h3F800000, 32'h40400000, 2'b11, 4'd4, 32'h3EAAAAAB, 5'h01);
        runOp("nthird_rdn",  32'hBF800000, 32'h40400000, 2'b10, 4'd6, 32'hBEAAAAAB, 5'h01);
        runOp("nthird_rup",  32'hBF800000, 32'h40400000, 2'b11, 4'd7, 32'hBEAAAAAA, 5'h01);

        // Special operands
        runOp("zero_zero",   32'h00000000, 32'h00000000, 2'b00, 4'd8,  32'h7FC00000, 5'h10);
        runOp("one_negzero", 32'h3F800000, 32'h80000000, 2'b00, 4'd9,  32'hFF800000, 5'h08);
        runOp("inf_inf",     32'h7F800000, 32'h7F800000, 2'b00, 4'd10, 32'h7FC00000, 5'h10);
        runOp("snan_one",    32'h7F800001, 32'h3F800000, 2'b00, 4'd11, 32'h7FC00000, 5'h10);
        runOp("qnan_one",    32'h7FC00000, 32'h3F800000, 2'b00, 4'd12, 32'h7FC00000, 5'h00);
        runOp("inf_two",     32'h7F800000, 32'h40000000, 2'b00, 4'd13, 32'h7F800000, 5'h00);
        runOp("negzero_one", 32'h80000000, 32'h3F800000, 2'b00, 4'd14, 32'h80000000, 5'h00);
        runOp("one_neginf",  32'h3F800000, 32'hFF800000, 2'b00, 4'd15, 32'h80000000, 5'h00);

        // Overflow
        runOp("ovf_rne",     32'h7F7FFFFF, 32'h3F000000, 2'b00, 4'd1, 32'h7F800000, 5'h05);
        runOp("ovf_rtz",     32'h7F7FFFFF, 32'h3F000000, 2'b01, 4'd2, 32'h7F7FFFFF, 5'h05);
        runOp("novf_rdn",    32'hFF7FFFFF, 32'h3F000000, 2'b10, 4'd3, 32'hFF800000, 5'h05);
        runOp("novf_rup",    32'hFF7FFFFF, 32'h3F000000, 2'b11, 4'd4, 32'hFF7FFFFF, 5'h05);

        // Subnormal range
        runOp("minnorm_half", 32'h00800000, 32'h40000000, 2'b00, 4'd5, 32'h00400000, 5'h00);
        runOp("sub_sub",      32'h00000001, 32'h00000001, 2'b00, 4'd6, 32'h3F800000, 5'h00);
        runOp("tie_to_zero",  32'h00000001, 32'h40000000, 2'b00, 4'd7, 32'h00000000, 5'h03);
        runOp("tie_rup",      32'h00000001, 32'h40000000, 2'b11, 4'd8, 32'h00000001, 5'h03);
        runOp("to_minnorm",   32'h00FFFFFF, 32'h40000000, 2'b00, 4'd9, 32'h00800000, 5'h03);
        runOp("sub_rtz",      32'h00FFFFFF, 32'h40000000, 2'b01, 4'd10, 32'h007FFFFF, 5'h03);

        // Streaming: 30 back-to-back random ops with random rounding modes, then a bubble
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            expV = (t >= 28) && (t <= 57);
            checkOutput("stream/valid", 64'(out_valid), 64'(expV));
            if (out_valid === 1'b1 && expQ.size() != 0) begin
                popped    = expQ.pop_front();
                poppedTag = tagQ.pop_front();
                checkOutput("stream/result", 64'(result),  64'(popped[31:0]));
                checkOutput("stream/flags",  64'(flags),   64'(popped[36:32]));
                checkOutput("stream/tag",    64'(out_tag), 64'(poppedTag));
            end
            if (t < 30) begin
                ra  = {1'($urandom_range(1, 0)), 8'($urandom_range(150, 100)), 23'($urandom)};
                rb  = {1'($urandom_range(1, 0)), 8'($urandom_range(150, 100)), 23'($urandom)};
                rrm = 2'($urandom_range(3, 0));
                applyStimulus(ra, rb, rrm, 4'(t));
                expQ.push_back(refDiv(ra, rb, rrm));
                tagQ.push_back(4'(t));
            end else begin
                idleInputs();
            end
        end
        checkOutput("stream/drained", 64'(expQ.size()), 64'd0);

        // Reset mid-flight: ten ops in flight, reset at cycle 12 for two cycles
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            if (t < 10) applyStimulus(32'h40C00000, 32'h40000000, 2'b00, 4'(t));
            else        idleInputs();
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset/valid",  64'(out_valid), 64'd0);
        checkOutput("midreset/result", 64'(result),    64'd0);
        checkOutput("midreset/flags",  64'(flags),     64'd0);
        checkOutput("midreset/tag",    64'(out_tag),   64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        strayValid = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) strayValid++;
        end
        checkOutput("midreset/stray", 64'(strayValid), 64'd0);
        runOp("after_reset", 32'h40C00000, 32'h40000000, 2'b00, 4'd12, 32'h40400000, 5'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
